posit_mul_arbiter: RTL

Shares a single `Posit_Multiplier` instance between two requesters via valid/ready handshakes. Round-robin arbitration issues at most one operand pair per cycle into the multiplier. Each result is tracked with a requester tag through the multiplier latency and returned in issue order through a per-requester result FIFO. Credit-based admission guarantees that no result is ever dropped.

---
 rtl/posit_mul_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/posit_mul_arbiter.sv
// Two-requester round-robin front end for one shared posit multiplier.
// Results are tagged through the multiplier latency and returned via per-requester FIFOs.
module posit_mul_arbiter #(
  parameter int N     = 8,
  parameter int es    = 3,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_out,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_out,
  output logic [N-1:0] mul_in1,
  output logic [N-1:0] mul_in2,
  input  logic [N-1:0] mul_out,
  output logic         idle
);
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] CRED_MAX = AW1'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || es < 0 || es > N - 2 || LAT < 0) begin : g_bad_params
    $error("posit_mul_arbiter: unsupported parameter set");
  end

  logic [1:0]   req_valid;
  logic [1:0]   rsp_ready;
  logic [1:0]   elig;
  logic [1:0]   cand;
  logic [1:0]   grant;
  logic [1:0]   pop;
  logic [1:0]   cap;
  logic [1:0]   rsp_vld;
  logic [1:0]   cnt_zero;
  logic [N-1:0] req_a [2];
  logic [N-1:0] req_b [2];
  logic [N-1:0] rsp_data [2];
  logic         last;
  logic [LAT:0] tag_vld_p;
  logic [LAT:0] tag_id_p;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a[0]  = req0_a;
  assign req_a[1]  = req1_a;
  assign req_b[0]  = req0_b;
  assign req_b[1]  = req1_b;
  assign cand      = req_valid & elig;

  // last=1 means req1 won the previous grant, so req0 takes the next tie
  always_comb begin
    grant = cand;
    if (&cand) grant = last ? 2'b01 : 2'b10;
  end

  assign req0_ready = grant[0] & rst_n;
  assign req1_ready = grant[1] & rst_n;

  // issue stage (p0) and tag shift pipeline through the multiplier latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      mul_in1   <= '0;
      mul_in2   <= '0;
      tag_vld_p <= '0;
      tag_id_p  <= '0;
    end else begin
      if (|grant) begin
        last    <= grant[1];
        mul_in1 <= grant[1] ? req_a[1] : req_a[0];
        mul_in2 <= grant[1] ? req_b[1] : req_b[0];
      end
      tag_vld_p[0] <= |grant;
      tag_id_p[0]  <= grant[1];
      for (int s = 1; s <= LAT; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
    end
  end

  assign cap[0] = tag_vld_p[LAT] & ~tag_id_p[LAT];
  assign cap[1] = tag_vld_p[LAT] &  tag_id_p[LAT];

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [AW:0]   cnt;
    logic [AW:0]   fill;
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [N-1:0]  mem [DEPTH];

    assign elig[g]     = cnt < CRED_MAX;
    assign rsp_vld[g]  = fill != '0;
    assign pop[g]      = rsp_ready[g] & rsp_vld[g];
    assign rsp_data[g] = mem[rd];
    assign cnt_zero[g] = cnt == '0;

    // capture stage: credits guarantee a slot exists whenever cap is high
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        fill <= '0;
        rd   <= '0;
        wr   <= '0;
        for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else begin
        if (cap[g]) begin
          mem[wr] <= mul_out;
          wr      <= wr + 1'b1;
        end
        if (pop[g]) rd <= rd + 1'b1;
        case ({cap[g], pop[g]})
          2'b10:   fill <= fill + 1'b1;
          2'b01:   fill <= fill - 1'b1;
          default: fill <= fill;
        endcase
        case ({grant[g], pop[g]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_out   = rsp_data[0];
  assign rsp1_out   = rsp_data[1];
  assign idle       = &cnt_zero;

endmodule
